// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit: owns HI/LO and sequences an iterative
// shift-add multiplier / restoring divider beside the single-cycle ALU.
module mdu_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] hilo_o,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              dbz_o
);
    localparam int CW = $clog2(DATA_W) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_a_q, neg_a_d;
    logic                dbz_q, dbz_d;
    logic                busy_q, busy_d;

    logic                is_launch, is_read, sgn_op, op_div;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum, div_r, div_diff;
    logic [2*DATA_W-1:0] mul_next, div_next, prod_fix;
    logic [DATA_W-1:0]   q_fix, r_fix;

    always_comb begin
        is_launch = (funct_i == F_MULT) || (funct_i == F_MULTU) ||
                    (funct_i == F_DIV)  || (funct_i == F_DIVU);
        is_read   = (funct_i == F_MFHI) || (funct_i == F_MFLO);
        sgn_op    = (funct_i == F_MULT) || (funct_i == F_DIV);
        op_div    = (funct_i == F_DIV)  || (funct_i == F_DIVU);
        a_mag     = (sgn_op && src1_i[DATA_W-1]) ? -src1_i : src1_i;
        b_mag     = (sgn_op && src2_i[DATA_W-1]) ? -src2_i : src2_i;
    end

    assign stall_o = start_i & busy_q & (is_launch | is_read);
    assign busy_o  = busy_q;
    assign done_o  = (state_q == S_DONE);
    assign dbz_o   = done_o & dbz_q;

    always_comb begin
        hilo_o = '0;
        if (start_i && funct_i == F_MFHI) hilo_o = hi_q;
        if (start_i && funct_i == F_MFLO) hilo_o = lo_q;
    end

    // Multiply: acc = {partial, multiplier}; add on LSB, then shift right.
    // Divide:   acc = {remainder, dividend}; shift left, subtract if it fits.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, b_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]}
                            : {1'b0, acc_q[2*DATA_W-1:1]};
        div_r    = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_diff = div_r - {1'b0, b_q};
        if (div_r >= {1'b0, b_q})
            div_next = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        else
            div_next = {div_r[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        prod_fix = neg_res_q ? -acc_q : acc_q;
        q_fix    = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        // remainder follows the dividend's sign; with a zero divisor it is the dividend itself
        r_fix    = neg_a_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        dbz_d     = dbz_q;
        case (state_q)
            S_IDLE: if (start_i && is_launch) begin
                state_d   = S_CALC;
                cnt_d     = '0;
                is_div_d  = op_div;
                neg_res_d = sgn_op & (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
                neg_a_d   = sgn_op & src1_i[DATA_W-1];
                dbz_d     = op_div & (src2_i == '0);
                acc_d     = op_div ? {{DATA_W{1'b0}}, a_mag} : {{DATA_W{1'b0}}, b_mag};
                b_d       = op_div ? b_mag : a_mag;
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_W - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (is_div_q) begin
                    lo_d = dbz_q ? '1 : q_fix;
                    hi_d = r_fix;
                end else begin
                    hi_d = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboarded bench for mdu_ctrl: expected HI/LO/dbz queued at launch,
// popped on done_o and checked through mfhi/mflo reads.
module tb_mdu_ctrl;
    localparam int W = 32;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD  = 6'b100000;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic         clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0;
    logic [5:0]   funct_i = '0;
    logic [W-1:0] src1_i = '0, src2_i = '0;
    logic [W-1:0] hilo_o;
    logic         busy_o, stall_o, done_o, dbz_o;

    exp_t         sb[$];
    int           n_chk = 0, n_err = 0, cyc = 0;
    logic [W-1:0] cur_hi = '0, cur_lo = '0;

    mdu_ctrl #(.DATA_W(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .funct_i(funct_i),
        .src1_i(src1_i), .src2_i(src2_i), .hilo_o(hilo_o), .busy_o(busy_o),
        .stall_o(stall_o), .done_o(done_o), .dbz_o(dbz_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd_hilo(input string tag);
        @(negedge clk_i);
        start_i = 1'b1; funct_i = F_MFHI; #1;
        chk({tag, "_hi"}, hilo_o, cur_hi);
        funct_i = F_MFLO; #1;
        chk({tag, "_lo"}, hilo_o, cur_lo);
        chk({tag, "_nostall"}, stall_o, 0);
        start_i = 1'b0; funct_i = '0;
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a, b,
                          input logic [W-1:0] ehi, elo, input logic edbz);
        int   t0;
        bit   seen;
        exp_t e;
        sb.push_back(exp_t'{ehi, elo, edbz});
        @(negedge clk_i);
        start_i = 1'b1; funct_i = f; src1_i = a; src2_i = b;
        @(posedge clk_i); #1 t0 = cyc;
        @(negedge clk_i);
        start_i = 1'b0; funct_i = '0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done_o) seen = 1;
            else @(negedge clk_i);
        end
        chk({tag, "_done"}, seen, 1);
        if (seen) begin
            // launch cycle is cycle 0, so done lands W+1 edges after the launch edge
            chk({tag, "_lat"}, cyc - t0, W + 1);
            e = sb.pop_front();
            chk({tag, "_dbz"}, dbz_o, e.dbz);
            cur_hi = e.hi; cur_lo = e.lo;
            rd_hilo(tag);
        end else begin
            sb.delete();
        end
    endtask

    initial begin
        int   bad, dones;
        bit   seen;
        exp_t e;
        logic [W-1:0] ra, rb;
        logic [63:0]  p;

        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_dbz", dbz_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        rd_hilo("rst");

        // reset in the middle of a multiply
        @(negedge clk_i);
        start_i = 1'b1; funct_i = F_MULTU; src1_i = '1; src2_i = '1;
        @(posedge clk_i);
        @(negedge clk_i);
        funct_i = F_MFHI;
        repeat (9) @(negedge clk_i);
        #1 chk("mid_stall_pre", stall_o, 1);
        rst_i = 1'b0; #1;
        chk("mid_busy", busy_o, 0);
        chk("mid_stall", stall_o, 0);
        chk("mid_done", done_o, 0);
        chk("mid_dbz", dbz_o, 0);
        chk("mid_hilo", hilo_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1; start_i = 1'b0; funct_i = '0;
        dones = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        chk("mid_nodone", dones, 0);
        rd_hilo("mid");

        run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult_neg", F_MULT, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("div_neg", F_DIV, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu_dbz", F_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1);
        run_op("div_dbz", F_DIV, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1);
        run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
        run_op("mult_pp", F_MULT, -32'sd4, -32'sd5, 32'h0, 32'd20, 0);

        for (int k = 0; k < 3; k++) begin
            ra = $urandom; rb = $urandom;
            p  = {32'b0, ra} * {32'b0, rb};
            run_op("rnd_multu", F_MULTU, ra, rb, p[63:32], p[31:0], 0);
            rb = rb | 32'd1;
            run_op("rnd_divu", F_DIVU, ra, rb, ra % rb, ra / rb, 0);
        end

        // stall and sequencing: multu 6*7 with MDU traffic while busy
        sb.push_back(exp_t'{32'd0, 32'd42, 1'b0});
        @(negedge clk_i);
        start_i = 1'b1; funct_i = F_MULTU; src1_i = 32'd6; src2_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0; funct_i = '0;
        repeat (4) @(negedge clk_i);
        start_i = 1'b1; funct_i = F_MFLO; #1;
        chk("st_mflo", stall_o, 1);
        chk("st_oldlo", hilo_o, cur_lo);
        @(negedge clk_i);
        funct_i = F_DIV; src1_i = 32'd100; src2_i = 32'd3; #1;
        chk("st_div", stall_o, 1);
        @(negedge clk_i);
        funct_i = F_ADD; #1;
        chk("st_add", stall_o, 0);
        chk("st_add_hilo", hilo_o, 0);
        funct_i = F_MFLO;
        bad = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i); #1;
            if (!stall_o) bad++;
            if (done_o) seen = 1;
        end
        chk("st_held", bad, 0);
        chk("st_done", seen, 1);
        if (seen) begin
            e = sb.pop_front();
            chk("st_dbz", dbz_o, e.dbz);
            cur_hi = e.hi; cur_lo = e.lo;
            @(negedge clk_i); #1;
            chk("st_release", stall_o, 0);
            chk("st_lo", hilo_o, cur_lo);
            funct_i = F_MFHI; #1;
            chk("st_hi", hilo_o, cur_hi);
        end else begin
            sb.delete();
        end
        start_i = 1'b0; funct_i = '0;
        repeat (3) @(negedge clk_i);
        chk("st_idle", busy_o, 0);
        rd_hilo("st_after");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
